// File: rtl/rom_streamer_if.sv
// Stream/ROM bundle for rom_streamer: burst request, ROM address/data and the
// ready/valid output stream. The streamer uses the master view.
interface rom_streamer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH:0]   length;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, start_addr, length, rom_data, out_ready,
      output rom_addr, out_data, out_valid, busy, done
   );

   modport slave (
      output start, start_addr, length, rom_data, out_ready,
      input  rom_addr, out_data, out_valid, busy, done
   );
endinterface

// File: rtl/rom_streamer.sv
// Streams a burst of consecutive ROM words (registered ROM, one cycle read
// latency) into a 2-entry ready/valid output FIFO without losing throughput.
module rom_streamer #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   rom_streamer_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic                  pending_q;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  rd_ptr_q, wr_ptr_q;
   logic [1:0]            count_q, count_d;
   logic [2:0]            occupancy;
   logic                  pop, issue;

   // A fetch may only go out if its word is guaranteed a FIFO slot on arrival.
   assign pop       = (count_q != 2'd0) && bus.out_ready;
   assign occupancy = {1'b0, count_q} + {2'b0, pending_q} - {2'b0, pop};
   assign issue     = (state_q == RUN) && (remaining_q != '0) && (occupancy < 3'd2);
   assign count_d   = count_q + {1'b0, pending_q} - {1'b0, pop};

   assign rom_addr_d    = issue ? addr_q : rom_addr_q;
   assign bus.rom_addr  = rom_addr_d;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_data  = fifo_q[rd_ptr_q];
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

   // NOTE: every variable gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.length != '0) begin
                  addr_d      = bus.start_addr;
                  remaining_d = bus.length;
                  state_d     = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (issue) begin
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - REM_ONE;
               if (remaining_q == REM_ONE) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Look at the post-edge FIFO level so done lands right after the last pop.
            if (!pending_q && count_d == 2'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         rom_addr_q  <= '0;
         pending_q   <= 1'b0;
         done_q      <= 1'b0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         // NOTE: the two FIFO entries are reset because the head drives out_data,
         // which must read zero out of reset.
         for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         rom_addr_q  <= rom_addr_d;
         pending_q   <= issue;
         done_q      <= done_d;
         count_q     <= count_d;
         if (pending_q) begin
            fifo_q[wr_ptr_q] <= bus.rom_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

endmodule
